// File: rtl/taus_pkg.sv
// Shared definitions for the taus88 uniform source: FSM states, step constants
// and the seed fix-up helper.
package taus_pkg;

    typedef enum logic [1:0] {
        ST_WARMUP = 2'd0,
        ST_RUN    = 2'd1,
        ST_LOAD   = 2'd2
    } taus_state_e;

    localparam int unsigned S1_SHL_A = 32'd13;
    localparam int unsigned S1_SHR   = 32'd19;
    localparam int unsigned S1_SHL_B = 32'd12;
    localparam int unsigned S2_SHL_A = 32'd2;
    localparam int unsigned S2_SHR   = 32'd25;
    localparam int unsigned S2_SHL_B = 32'd4;
    localparam int unsigned S3_SHL_A = 32'd3;
    localparam int unsigned S3_SHR   = 32'd11;
    localparam int unsigned S3_SHL_B = 32'd17;

    localparam logic [31:0] S1_MASK = 32'hFFFF_FFFE;
    localparam logic [31:0] S2_MASK = 32'hFFFF_FFF8;
    localparam logic [31:0] S3_MASK = 32'hFFFF_FFF0;

    localparam logic [31:0] S1_MIN = 32'd2;
    localparam logic [31:0] S2_MIN = 32'd8;
    localparam logic [31:0] S3_MIN = 32'd16;

    localparam logic [2:0] LOAD_LAST = 3'd5;

    // Seeds below the minimum collapse the component to a degenerate cycle.
    function automatic logic [31:0] seed_fix(input logic [31:0] word, input logic [31:0] min_val);
        logic [31:0] res;
        if (word < min_val) begin
            res = min_val;
        end else begin
            res = word;
        end
        return res;
    endfunction

endpackage

// File: rtl/taus88_step.sv
// One combinational step of a taus88 combined Tausworthe generator.
module taus88_step
    import taus_pkg::*;
(
    input  logic [31:0] s1,
    input  logic [31:0] s2,
    input  logic [31:0] s3,
    output logic [31:0] s1_next,
    output logic [31:0] s2_next,
    output logic [31:0] s3_next,
    output logic [31:0] rnd
);

    logic [31:0] t1_s;
    logic [31:0] t2_s;
    logic [31:0] t3_s;

    assign t1_s = ((s1 << S1_SHL_A) ^ s1) >> S1_SHR;
    assign t2_s = ((s2 << S2_SHL_A) ^ s2) >> S2_SHR;
    assign t3_s = ((s3 << S3_SHL_A) ^ s3) >> S3_SHR;

    assign s1_next = ((s1 & S1_MASK) << S1_SHL_B) ^ t1_s;
    assign s2_next = ((s2 & S2_MASK) << S2_SHL_B) ^ t2_s;
    assign s3_next = ((s3 & S3_MASK) << S3_SHL_B) ^ t3_s;

    assign rnd = s1_next ^ s2_next ^ s3_next;

endmodule

// File: rtl/taus_urng.sv
// Dual taus88 uniform source with seed loading, warm-up discard and
// enable-driven streaming of the a/b word pair.
module taus_urng
    import taus_pkg::*;
#(
    parameter int unsigned WARMUP_CYCLES = 32'd16,
    parameter logic [31:0] DEF_SEED_A1   = 32'h1234_5678,
    parameter logic [31:0] DEF_SEED_A2   = 32'h9ABC_DEF0,
    parameter logic [31:0] DEF_SEED_A3   = 32'h0F1E_2D3C,
    parameter logic [31:0] DEF_SEED_B1   = 32'hCAFE_F00D,
    parameter logic [31:0] DEF_SEED_B2   = 32'hDEAD_BEEF,
    parameter logic [31:0] DEF_SEED_B3   = 32'h7654_3210
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        seed_valid,
    input  logic [31:0] seed_data,
    output logic        seed_ready,
    input  logic        en,
    output logic [31:0] a,
    output logic [31:0] b,
    output logic        ovalid
);

    localparam logic [31:0] WARM_LAST = WARMUP_CYCLES - 32'd1;
    localparam taus_state_e POST_LOAD = (WARMUP_CYCLES == 32'd0) ? ST_RUN : ST_WARMUP;

    taus_state_e state_r;
    taus_state_e state_s;
    logic [31:0] warm_cnt_r;
    logic [2:0]  load_cnt_r;
    logic        step_s;
    logic        run_step_s;
    logic        load_we_s;

    logic [31:0] a_s1_r, a_s2_r, a_s3_r;
    logic [31:0] b_s1_r, b_s2_r, b_s3_r;
    logic [31:0] a_s1_nx_s, a_s2_nx_s, a_s3_nx_s;
    logic [31:0] b_s1_nx_s, b_s2_nx_s, b_s3_nx_s;
    logic [31:0] rnd_a_s, rnd_b_s;

    logic [31:0] a_r, b_r;
    logic        ovalid_r;
    logic        seed_ready_r;

    taus88_step u_step_a (
        .s1      (a_s1_r),
        .s2      (a_s2_r),
        .s3      (a_s3_r),
        .s1_next (a_s1_nx_s),
        .s2_next (a_s2_nx_s),
        .s3_next (a_s3_nx_s),
        .rnd     (rnd_a_s)
    );

    taus88_step u_step_b (
        .s1      (b_s1_r),
        .s2      (b_s2_r),
        .s3      (b_s3_r),
        .s1_next (b_s1_nx_s),
        .s2_next (b_s2_nx_s),
        .s3_next (b_s3_nx_s),
        .rnd     (rnd_b_s)
    );

    // Next-state decode; a seed handshake in RUN takes priority over en.
    always_comb begin
        state_s    = state_r;
        step_s     = 1'b0;
        run_step_s = 1'b0;
        load_we_s  = 1'b0;
        case (state_r)
            ST_WARMUP: begin
                if (WARMUP_CYCLES == 32'd0) begin
                    state_s = ST_RUN;
                end else begin
                    step_s = 1'b1;
                    if (warm_cnt_r == WARM_LAST) begin
                        state_s = ST_RUN;
                    end else begin
                        state_s = ST_WARMUP;
                    end
                end
            end
            ST_RUN: begin
                if (seed_valid) begin
                    load_we_s = 1'b1;
                    state_s   = ST_LOAD;
                end else if (en) begin
                    step_s     = 1'b1;
                    run_step_s = 1'b1;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_LOAD: begin
                if (seed_valid) begin
                    load_we_s = 1'b1;
                    if (load_cnt_r == LOAD_LAST) begin
                        state_s = POST_LOAD;
                    end else begin
                        state_s = ST_LOAD;
                    end
                end else begin
                    state_s = ST_LOAD;
                end
            end
            default: begin
                state_s = ST_WARMUP;
            end
        endcase
    end

    // State register; seed_ready is registered from the next state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r      <= ST_WARMUP;
            seed_ready_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            seed_ready_r <= (state_s != ST_WARMUP);
        end
    end

    // Warm-up step counter, cleared whenever WARMUP is not active.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            warm_cnt_r <= 32'd0;
        end else if (state_r == ST_WARMUP && state_s == ST_WARMUP) begin
            warm_cnt_r <= warm_cnt_r + 32'd1;
        end else begin
            warm_cnt_r <= 32'd0;
        end
    end

    // Seed word index; the RUN handshake always lands on index 0.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            load_cnt_r <= 3'd0;
        end else if (load_we_s) begin
            load_cnt_r <= (load_cnt_r == LOAD_LAST) ? 3'd0 : load_cnt_r + 3'd1;
        end else begin
            load_cnt_r <= load_cnt_r;
        end
    end

    // Generator state: defaults on reset, seed writes, or one step.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            a_s1_r <= seed_fix(DEF_SEED_A1, S1_MIN);
            a_s2_r <= seed_fix(DEF_SEED_A2, S2_MIN);
            a_s3_r <= seed_fix(DEF_SEED_A3, S3_MIN);
            b_s1_r <= seed_fix(DEF_SEED_B1, S1_MIN);
            b_s2_r <= seed_fix(DEF_SEED_B2, S2_MIN);
            b_s3_r <= seed_fix(DEF_SEED_B3, S3_MIN);
        end else if (load_we_s) begin
            case (load_cnt_r)
                3'd0:    a_s1_r <= seed_fix(seed_data, S1_MIN);
                3'd1:    a_s2_r <= seed_fix(seed_data, S2_MIN);
                3'd2:    a_s3_r <= seed_fix(seed_data, S3_MIN);
                3'd3:    b_s1_r <= seed_fix(seed_data, S1_MIN);
                3'd4:    b_s2_r <= seed_fix(seed_data, S2_MIN);
                3'd5:    b_s3_r <= seed_fix(seed_data, S3_MIN);
                default: a_s1_r <= a_s1_r;
            endcase
        end else if (step_s) begin
            a_s1_r <= a_s1_nx_s;
            a_s2_r <= a_s2_nx_s;
            a_s3_r <= a_s3_nx_s;
            b_s1_r <= b_s1_nx_s;
            b_s2_r <= b_s2_nx_s;
            b_s3_r <= b_s3_nx_s;
        end else begin
            a_s1_r <= a_s1_r;
            a_s2_r <= a_s2_r;
            a_s3_r <= a_s3_r;
            b_s1_r <= b_s1_r;
            b_s2_r <= b_s2_r;
            b_s3_r <= b_s3_r;
        end
    end

    // Output words change only on RUN steps; ovalid pulses with them.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            a_r      <= 32'd0;
            b_r      <= 32'd0;
            ovalid_r <= 1'b0;
        end else if (run_step_s) begin
            a_r      <= rnd_a_s;
            b_r      <= rnd_b_s;
            ovalid_r <= 1'b1;
        end else begin
            a_r      <= a_r;
            b_r      <= b_r;
            ovalid_r <= 1'b0;
        end
    end

    assign a          = a_r;
    assign b          = b_r;
    assign ovalid     = ovalid_r;
    assign seed_ready = seed_ready_r;

endmodule

// File: tb/tb_taus_urng.sv
// Bench for taus_urng: a 16-cycle warm-up instance and a zero warm-up
// instance checked every cycle against a transaction-level taus88 model.
module tb_taus_urng;

    typedef enum {P_WARM, P_RUN, P_LOAD} phase_e;

    typedef struct {
        logic        en_v;
        logic        sv_v;
        logic [31:0] sd_v;
        logic        ov_e;
        logic        chk_ab;
        logic [31:0] ab_e;
    } vec_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        en [2];
    logic        seed_valid [2];
    logic [31:0] seed_data [2];
    logic        seed_ready [2];
    logic [31:0] a [2];
    logic [31:0] b [2];
    logic        ovalid [2];

    always #5 clk = ~clk;

    taus_urng u_w16 (
        .clk(clk), .resetn(resetn), .seed_valid(seed_valid[0]), .seed_data(seed_data[0]),
        .seed_ready(seed_ready[0]), .en(en[0]), .a(a[0]), .b(b[0]), .ovalid(ovalid[0])
    );

    taus_urng #(.WARMUP_CYCLES(32'd0)) u_w0 (
        .clk(clk), .resetn(resetn), .seed_valid(seed_valid[1]), .seed_data(seed_data[1]),
        .seed_ready(seed_ready[1]), .en(en[1]), .a(a[1]), .b(b[1]), .ovalid(ovalid[1])
    );

    int unsigned wu [2];
    phase_e      ph [2];
    int unsigned ms [2][6];
    int unsigned exp_a [2];
    int unsigned exp_b [2];
    logic        exp_ov [2];
    int          warm_left [2];
    int          ld_cnt [2];
    logic        nx_en [2];
    logic        nx_sv [2];
    logic [31:0] nx_sd [2];
    int unsigned m_a, m_b;
    int          vectors = 0;
    int          miscompares = 0;
    vec_t        tbl [11];

    function automatic int unsigned fix(input int unsigned w, input int k);
        int unsigned mn;
        mn = (k % 3 == 0) ? 32'd2 : ((k % 3 == 1) ? 32'd8 : 32'd16);
        return (w < mn) ? mn : w;
    endfunction

    // Plain-arithmetic taus88 step of both generators of instance i.
    task automatic m_advance(input int i);
        int unsigned s1, s2, s3, t;
        int unsigned o [2];
        for (int g = 0; g < 2; g++) begin
            s1 = ms[i][3*g]; s2 = ms[i][3*g+1]; s3 = ms[i][3*g+2];
            t = ((s1 << 13) ^ s1) >> 19; s1 = ((s1 & 32'hFFFFFFFE) << 12) ^ t;
            t = ((s2 << 2) ^ s2) >> 25;  s2 = ((s2 & 32'hFFFFFFF8) << 4) ^ t;
            t = ((s3 << 3) ^ s3) >> 11;  s3 = ((s3 & 32'hFFFFFFF0) << 17) ^ t;
            ms[i][3*g] = s1; ms[i][3*g+1] = s2; ms[i][3*g+2] = s3;
            o[g] = s1 ^ s2 ^ s3;
        end
        m_a = o[0];
        m_b = o[1];
    endtask

    task automatic m_reset(input int i);
        ms[i][0] = fix(32'h1234_5678, 0); ms[i][1] = fix(32'h9ABC_DEF0, 1);
        ms[i][2] = fix(32'h0F1E_2D3C, 2); ms[i][3] = fix(32'hCAFE_F00D, 3);
        ms[i][4] = fix(32'hDEAD_BEEF, 4); ms[i][5] = fix(32'h7654_3210, 5);
        exp_a[i] = 0; exp_b[i] = 0; exp_ov[i] = 1'b0;
        ph[i] = P_WARM; warm_left[i] = int'(wu[i]); ld_cnt[i] = 0;
    endtask

    task automatic m_load(input int i);
        ms[i][ld_cnt[i]] = fix(nx_sd[i], ld_cnt[i]);
        ld_cnt[i]++;
        if (ld_cnt[i] == 6) begin
            ld_cnt[i] = 0;
            warm_left[i] = int'(wu[i]);
            ph[i] = (wu[i] == 0) ? P_RUN : P_WARM;
        end else begin
            ph[i] = P_LOAD;
        end
    endtask

    // Effect of the coming clock edge on instance i, from the spec rules.
    task automatic predict(input int i);
        exp_ov[i] = 1'b0;
        case (ph[i])
            P_WARM: begin
                if (warm_left[i] == 0) begin
                    ph[i] = P_RUN;
                end else begin
                    m_advance(i);
                    warm_left[i]--;
                    if (warm_left[i] == 0) ph[i] = P_RUN;
                end
            end
            P_RUN: begin
                if (nx_sv[i]) begin
                    m_load(i);
                end else if (nx_en[i]) begin
                    m_advance(i);
                    exp_a[i] = m_a; exp_b[i] = m_b; exp_ov[i] = 1'b1;
                end
            end
            default: begin
                if (nx_sv[i]) m_load(i);
            end
        endcase
    endtask

    task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s[inst %0d] @%0t: got %h, expected %h", name, i, $time, act, expv);
        end
    endtask

    task automatic tick();
        for (int i = 0; i < 2; i++) predict(i);
        for (int i = 0; i < 2; i++) begin
            en[i] = nx_en[i]; seed_valid[i] = nx_sv[i]; seed_data[i] = nx_sd[i];
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("ovalid", i, 32'(ovalid[i]), 32'(exp_ov[i]));
            chk("a", i, a[i], exp_a[i]);
            chk("b", i, b[i], exp_b[i]);
            chk("seed_ready", i, 32'(seed_ready[i]), 32'(ph[i] != P_WARM));
            nx_en[i] = 1'b0; nx_sv[i] = 1'b0; nx_sd[i] = 32'd0;
        end
    endtask

    task automatic cyc(input int i, input logic e, input logic v, input logic [31:0] d);
        nx_en[i] = e; nx_sv[i] = v; nx_sd[i] = d;
        tick();
    endtask

    // Mid-cycle asynchronous reset of both instances, released one edge later.
    task automatic do_reset();
        resetn = 1'b0;
        for (int i = 0; i < 2; i++) begin
            en[i] = 1'b0; seed_valid[i] = 1'b0; seed_data[i] = 32'd0;
            nx_en[i] = 1'b0; nx_sv[i] = 1'b0; nx_sd[i] = 32'd0;
        end
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("rst_a", i, a[i], 32'd0);
            chk("rst_b", i, b[i], 32'd0);
            chk("rst_ovalid", i, 32'(ovalid[i]), 32'd0);
            chk("rst_seed_ready", i, 32'(seed_ready[i]), 32'd0);
        end
        @(posedge clk);
        #1;
        resetn = 1'b1;
        for (int i = 0; i < 2; i++) m_reset(i);
    endtask

    function automatic logic [31:0] rnd_word();
        return ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom();
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        wu[0] = 32'd16;
        wu[1] = 32'd0;
        for (int i = 0; i < 2; i++) begin
            en[i] = 1'b0; seed_valid[i] = 1'b0; seed_data[i] = 32'd0;
            nx_en[i] = 1'b0; nx_sv[i] = 1'b0; nx_sd[i] = 32'd0;
        end

        for (int k = 0; k < 6; k++) tbl[k] = '{1'b0, 1'b1, 32'd0, 1'b0, 1'b0, 32'd0};
        tbl[6]  = '{1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 32'h0020_2080};
        tbl[7]  = '{1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 32'h0200_2C80};
        tbl[8]  = '{1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'h0200_2C80};
        tbl[9]  = '{1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 32'h4808_8062};
        tbl[10] = '{1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0};

        @(posedge clk);
        #1;
        do_reset();
        for (int k = 0; k < 20; k++) tick();

        // Zero seeds on the zero warm-up instance, then en 1,1,0,1,1.
        for (int k = 0; k < 11; k++) begin
            cyc(1, tbl[k].en_v, tbl[k].sv_v, tbl[k].sd_v);
            chk("tbl_ovalid", 1, 32'(ovalid[1]), 32'(tbl[k].ov_e));
            if (tbl[k].chk_ab) begin
                chk("tbl_a", 1, a[1], tbl[k].ab_e);
                chk("tbl_b", 1, b[1], tbl[k].ab_e);
            end
        end

        // Seed word and en together in RUN: word taken, no step.
        cyc(0, 1'b1, 1'b1, rnd_word());
        chk("conflict_ovalid", 0, 32'(ovalid[0]), 32'd0);
        chk("conflict_ready", 0, 32'(seed_ready[0]), 32'd1);

        // Remaining five words with 3-cycle gaps; en held high is ignored.
        for (int w = 0; w < 5; w++) begin
            for (int g = 0; g < 3; g++) cyc(0, 1'b1, 1'b0, 32'd0);
            cyc(0, 1'b1, 1'b1, rnd_word());
        end
        for (int k = 0; k < 40 && ph[0] != P_RUN; k++) cyc(0, 1'b1, 1'b0, 32'd0);
        cyc(0, 1'b1, 1'b0, 32'd0);
        chk("first_en_after_load", 0, 32'(ovalid[0]), 32'd1);

        // Reset after three words restores the default stream.
        for (int w = 0; w < 3; w++) cyc(0, 1'b0, 1'b1, rnd_word());
        do_reset();
        for (int k = 0; k < 40 && ph[0] != P_RUN; k++) tick();
        for (int k = 0; k < 20; k++) cyc(0, 1'b1, 1'b0, 32'd0);

        // Random traffic on both instances.
        for (int k = 0; k < 600; k++) begin
            for (int i = 0; i < 2; i++) begin
                nx_en[i] = 1'($urandom_range(0, 1));
                nx_sv[i] = (ph[i] == P_LOAD) ? 1'($urandom_range(0, 1))
                                             : ($urandom_range(0, 19) == 0);
                nx_sd[i] = rnd_word();
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/taus_urng.md
# taus_urng

Uniform random source feeding the Box-Muller noise core: two independent taus88 combined Tausworthe generators produce the 32-bit seed words `a` and `b` consumed by `myAWGN`, one fresh pair per enabled cycle. The block owns seed loading over a valid/ready handshake, fixes illegal seeds, discards a programmable warm-up run, and then streams.

## Interface
- `WARMUP_CYCLES`, 16: generator steps discarded after reset or after a seed load; 0 is legal.
- `DEF_SEED_A1`, `DEF_SEED_A2`, `DEF_SEED_A3`, 32'h1234_5678 / 32'h9ABC_DEF0 / 32'h0F1E_2D3C: reset seeds, generator A.
- `DEF_SEED_B1`, `DEF_SEED_B2`, `DEF_SEED_B3`, 32'hCAFE_F00D / 32'hDEAD_BEEF / 32'h7654_3210: reset seeds, generator B.
- `clk` in 1: clock.
- `resetn` in 1: asynchronous, active-low reset.
- `seed_valid` in 1: `seed_data` holds a seed word.
- `seed_data` in 32: seed word.
- `seed_ready` out 1: block accepts a seed word this cycle.
- `en` in 1: request one output pair (RUN only).
- `a` out 32: uniform word A, to `myAWGN.a`.
- `b` out 32: uniform word B, to `myAWGN.b`.
- `ovalid` out 1: `a`/`b` updated this cycle.

## Operation
- Each generator holds three 32-bit components s1, s2, s3. One step, all unsigned, 32-bit truncation:
  - t = ((s1<<13)^s1)>>19; s1' = ((s1 & FFFFFFFE)<<12)^t
  - t = ((s2<<2)^s2)>>25; s2' = ((s2 & FFFFFFF8)<<4)^t
  - t = ((s3<<3)^s3)>>11; s3' = ((s3 & FFFFFFF0)<<17)^t
  - output = s1'^s2'^s3'.
- Seed fix-up on every write, defaults included: s1<2 → 2; s2<8 → 8; s3<16 → 16.
- States:
  - WARMUP: both generators step every cycle. Count reaches WARMUP_CYCLES → RUN. With WARMUP_CYCLES=0, go straight to RUN.
  - RUN: `en`=1 steps both generators and registers the outputs; `en`=0 holds everything.
  - LOAD: accepted words fill A.s1, A.s2, A.s3, B.s1, B.s2, B.s3, in that order, using a 3-bit counter. After the 6th word → WARMUP.
- `seed_ready` = 1 in RUN and LOAD; 0 in WARMUP.
- A handshake in RUN (`seed_valid`&`seed_ready`) stores word 0 and enters LOAD. That cycle does not step, even if `en`=1.
- LOAD ignores `en`. Gaps in `seed_valid` are allowed; the counter holds.
- `a`, `b` are unchanged outside RUN steps.

## Timing
- Reset (async assert, sync release): s = fixed-up defaults, state WARMUP, warm-up count 0, `a`=`b`=0, `ovalid`=0.
- Latency from `en` sampled high in RUN to new `a`/`b` with `ovalid`=1: 1 cycle. Back-to-back `en` gives one pair per cycle.
- `ovalid` is a 1-cycle pulse per step; it is never asserted in LOAD or WARMUP.
- Time to stream after a load: the 6th handshake, then WARMUP_CYCLES cycles, then RUN, where the first `en` is honoured.
- Reset mid-LOAD or mid-WARMUP: the partial load is discarded and defaults are restored.

## Structure
- Package `taus_pkg`:
  - state enum (WARMUP, RUN, LOAD)
  - shift constants (13/19/12, 2/25/4, 3/11/17)
  - masks FFFFFFFE/FFFFFFF8/FFFFFFF0
  - minimum seeds 2/8/16
  - fix-up function.
- Sub-module `taus88_step`: combinational; 3×32 state in, 3×32 next state and 32-bit output out. Instantiated twice (A, B).
- Top-level holds the FSM, counters, seed registers and output registers.

## Test plan
- **Reset values:** assert `resetn`=0 mid-cycle → `a`=`b`=0, `ovalid`=0, `seed_ready`=0 immediately; release → `seed_ready` rises after exactly 16 cycles.
- **Zero seeds / fix-up:** WARMUP_CYCLES=0; load six words 0. Pulse `en` twice → `a`=`b`=32'h0020_2080, then 32'h0200_2C80, `ovalid` high on both cycles.
- **Stalls and back-to-back:** in RUN, `en` pattern 1,0,1,1 → `ovalid` 1,0,1,1 one cycle later; `a` is unchanged across the stall; after the load above, the third step follows 32'h0200_2C80 correctly.
- **Load with gaps:** `seed_valid` toggling with 3-cycle gaps; 6 words accepted, no `ovalid` during LOAD, and the next `en` is honoured only after warm-up.
- **Seed vs enable conflict:** `seed_valid` and `en` both high in RUN → word captured, no step, `ovalid`=0.
- **Reset mid-load:** reset after 3 words → outputs match a fresh-reset golden stream (C taus88 model with default seeds).
